// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state codes,
// decoded opcodes and exception causes.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned EXC_W   = 2;

    // Codes 12..14 are deliberately unassigned; the FSM recovers to FETCH.
    typedef enum logic [STATE_W-1:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_WB_MEM   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_WB_R     = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_EXEC_I   = 4'd10,
        ST_WB_I     = 4'd11,
        ST_EXC      = 4'd15
    } state_e;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OPC_W-1:0] OP_J     = 6'd2;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'd3;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'd5;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'd8;
    localparam logic [OPC_W-1:0] OP_SLTI  = 6'd10;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'd12;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'd13;
    localparam logic [OPC_W-1:0] OP_LW    = 6'd35;
    localparam logic [OPC_W-1:0] OP_SW    = 6'd43;

    localparam logic [EXC_W-1:0] EXC_NONE    = 2'd0;
    localparam logic [EXC_W-1:0] EXC_ILLEGAL = 2'd1;
    localparam logic [EXC_W-1:0] EXC_BUS     = 2'd2;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control-unit bus: IR fields and handshakes in, state code and datapath
// strobes out.
//   master: the control unit (drives state/strobes/status)
//   slave : the IR/memory/datapath side (drives opcode/zero/mem_ready/exc_clear)
interface mc_control_fsm_if #(
    parameter int unsigned CNT_W = 16
);
    import mc_ctrl_pkg::*;

    logic [OPC_W-1:0]   opcode;
    logic               zero;
    logic               mem_ready;
    logic               exc_clear;
    logic [STATE_W-1:0] state;
    logic               mem_req;
    logic               mem_we;
    logic               ir_write;
    logic               pc_write;
    logic               reg_write;
    logic               finish;
    logic               exc;
    logic [EXC_W-1:0]   exc_code;
    logic [CNT_W-1:0]   retired;

    modport master (
        input  opcode, zero, mem_ready, exc_clear,
        output state, mem_req, mem_we, ir_write, pc_write, reg_write,
               finish, exc, exc_code, retired
    );

    modport slave (
        output opcode, zero, mem_ready, exc_clear,
        input  state, mem_req, mem_we, ir_write, pc_write, reg_write,
               finish, exc, exc_code, retired
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags a bus timeout.
//   clk, rst : clock, async active-high reset
//   waiting  : in a memory state with mem_ready low this cycle
//   restart  : the FSM changes state at the next edge
//   timeout  : WAIT_LIMIT wait cycles already elapsed and still waiting
// WAIT_LIMIT = 0 disables the timeout.
module mem_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic restart,
    output logic timeout
);

    localparam int unsigned TW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

    logic [TW-1:0] count_q;

    // count_q holds the number of wait cycles already spent in this state
    assign timeout = (WAIT_LIMIT != 0) && waiting && (count_q == TW'(WAIT_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (restart) begin
            count_q <= '0;
        end else if (waiting && !timeout) begin
            count_q <= count_q + TW'(1);
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: state register, next-state decode from
// opcode and handshakes, per-state datapath strobes, exception capture and
// retired-instruction counter.
//   clk, rst : clock, async active-high reset
//   bus      : mc_control_fsm_if.master (opcode/zero/mem_ready/exc_clear in;
//              state, strobes, exc_code, retired out)
// state, exc_code and retired are registered; strobes decode the current
// state and the handshake inputs.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    mc_control_fsm_if.master    bus
);

    state_e             state_q, state_d;
    logic [EXC_W-1:0]   exc_code_q, exc_code_d;
    logic [CNT_W-1:0]   retired_q;

    logic waiting_c;
    logic restart_c;
    logic timeout_c;

    logic mem_req_c, mem_we_c, ir_write_c, pc_write_c;
    logic reg_write_c, finish_c, exc_c;

    // Only stalled memory accesses run the wait timer
    assign waiting_c = ((state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                        (state_q == ST_MEM_WR)) && !bus.mem_ready;
    assign restart_c = (state_d != state_q);

    mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .waiting (waiting_c),
        .restart (restart_c),
        .timeout (timeout_c)
    );

    // Next state and exception cause; mem_ready has priority over timeout
    always_comb begin
        state_d    = state_q;
        exc_code_d = exc_code_q;
        case (state_q)
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = ST_DECODE;
                end else if (timeout_c) begin
                    state_d    = ST_EXC;
                    exc_code_d = EXC_BUS;
                end
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:                     state_d = ST_MEM_ADDR;
                    OP_RTYPE:                         state_d = ST_EXEC_R;
                    OP_BEQ, OP_BNE:                   state_d = ST_BRANCH;
                    OP_J, OP_JAL:                     state_d = ST_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = ST_EXEC_I;
                    default: begin
                        state_d    = ST_EXC;
                        exc_code_d = EXC_ILLEGAL;
                    end
                endcase
            end
            ST_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (bus.mem_ready) begin
                    state_d = ST_WB_MEM;
                end else if (timeout_c) begin
                    state_d    = ST_EXC;
                    exc_code_d = EXC_BUS;
                end
            end
            ST_MEM_WR: begin
                if (bus.mem_ready) begin
                    state_d = ST_FETCH;
                end else if (timeout_c) begin
                    state_d    = ST_EXC;
                    exc_code_d = EXC_BUS;
                end
            end
            ST_EXEC_R: state_d = ST_WB_R;
            ST_EXEC_I: state_d = ST_WB_I;
            ST_WB_MEM, ST_WB_R, ST_WB_I, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
            ST_EXC: begin
                if (bus.exc_clear) begin
                    state_d    = ST_FETCH;
                    exc_code_d = EXC_NONE;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Datapath strobes
    always_comb begin
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        finish_c    = 1'b0;
        exc_c       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req_c  = 1'b1;
                ir_write_c = bus.mem_ready;
                pc_write_c = bus.mem_ready;
            end
            ST_MEM_RD: mem_req_c = 1'b1;
            ST_MEM_WR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                finish_c  = bus.mem_ready;
            end
            ST_WB_MEM, ST_WB_R, ST_WB_I: begin
                reg_write_c = 1'b1;
                finish_c    = 1'b1;
            end
            ST_BRANCH: begin
                // bne inverts the sense of the zero flag
                pc_write_c = bus.zero ^ (bus.opcode == OP_BNE);
                finish_c   = 1'b1;
            end
            ST_JUMP: begin
                pc_write_c  = 1'b1;
                reg_write_c = (bus.opcode == OP_JAL);
                finish_c    = 1'b1;
            end
            ST_EXC: exc_c = 1'b1;
            default: ;
        endcase
    end

    // State, exception cause and retirement counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            exc_code_q <= EXC_NONE;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            exc_code_q <= exc_code_d;
            if (finish_c) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign bus.state     = state_q;
    assign bus.mem_req   = mem_req_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.ir_write  = ir_write_c;
    assign bus.pc_write  = pc_write_c;
    assign bus.reg_write = reg_write_c;
    assign bus.finish    = finish_c;
    assign bus.exc       = exc_c;
    assign bus.exc_code  = exc_code_q;
    assign bus.retired   = retired_q;

endmodule
